// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Two-port round-robin arbiter in front of a single-word data memory.
//   Each granted access runs IDLE -> ACCESS -> RESP, one cycle per state.
//   In ACCESS the memory strobe fires, and in RESP the winner gets its ack.
//   Misaligned or out-of-range word addresses are rejected: no strobe is
//   issued, and the ack carries err_o=1.
// Ports
//   clk_i, rst_i              clock, asynchronous active-low reset
//   req*_i, we*_i             request and write-enable per requester
//   addr*_i, wdata*_i         byte address and write data per requester
//   ack*_o, err_o, rdata_o    one-cycle completion, reject flag, read data
//   busy_o, gnt_o             not-IDLE flag, owning / last-served requester
//   mem_addr_o, mem_wdata_o   memory address and write data
//   mem_read_o, mem_write_o   memory read and write strobes
//   mem_rdata_i               memory read data (little-endian word)
module data_mem_arbiter #(
    parameter int MEM_BYTES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        we0_i,
    input  logic        we1_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        gnt_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_r;
    logic        last_r;     // last-served requester; also the winner while busy
    logic        we_r;
    logic        bad_r;
    logic        sel_s;
    logic        sel_we_s;
    logic        sel_bad_s;
    logic        any_req_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;

    // An address is rejected when it is not word aligned or its word runs past the end of memory.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a > LAST_ADDR);
    endfunction

    // Pick the winner. On a tie, the requester that was not served last wins.
    always_comb begin
        any_req_s = req0_i | req1_i;
        if (req0_i && req1_i) begin
            sel_s = ~last_r;
        end else if (req1_i) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
        if (sel_s) begin
            sel_we_s    = we1_i;
            sel_addr_s  = addr1_i;
            sel_wdata_s = wdata1_i;
        end else begin
            sel_we_s    = we0_i;
            sel_addr_s  = addr0_i;
            sel_wdata_s = wdata0_i;
        end
        sel_bad_s = addr_bad(sel_addr_s);
    end

    // The FSM sets every output register directly, so outputs are already valid in the state they belong to.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= IDLE;
            last_r      <= 1'b1;
            we_r        <= 1'b0;
            bad_r       <= 1'b0;
            ack0_o      <= 1'b0;
            ack1_o      <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= 32'h0000_0000;
            busy_o      <= 1'b0;
            mem_addr_o  <= 32'h0000_0000;
            mem_wdata_o <= 32'h0000_0000;
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r     <= ACCESS;
                        busy_o      <= 1'b1;
                        last_r      <= sel_s;
                        we_r        <= sel_we_s;
                        bad_r       <= sel_bad_s;
                        mem_addr_o  <= sel_addr_s;
                        mem_wdata_o <= sel_wdata_s;
                        mem_read_o  <= ~sel_we_s & ~sel_bad_s;
                        mem_write_o <= sel_we_s & ~sel_bad_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    state_r     <= RESP;
                    mem_read_o  <= 1'b0;
                    mem_write_o <= 1'b0;
                    ack0_o      <= ~last_r;
                    ack1_o      <= last_r;
                    err_o       <= bad_r;
                    rdata_o     <= (!we_r && !bad_r) ? mem_rdata_i : 32'h0000_0000;
                end
                RESP: begin
                    state_r <= IDLE;
                    busy_o  <= 1'b0;
                    ack0_o  <= 1'b0;
                    ack1_o  <= 1'b0;
                    err_o   <= 1'b0;
                    rdata_o <= 32'h0000_0000;
                end
                default: begin
                    state_r     <= IDLE;
                    busy_o      <= 1'b0;
                    ack0_o      <= 1'b0;
                    ack1_o      <= 1'b0;
                    err_o       <= 1'b0;
                    rdata_o     <= 32'h0000_0000;
                    mem_read_o  <= 1'b0;
                    mem_write_o <= 1'b0;
                end
            endcase
        end
    end

    // last_r already means "winner" while busy and "last served" while idle.
    assign gnt_o = last_r;

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 32, meaning byte capacity of the attached data memory; legal word addresses are 0..MEM_BYTES-4.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 req0_i / req1_i  input  1 each  access request from requester 0 / 1.
REQ-005 we0_i / we1_i  input  1 each  1 = word write, 0 = word read.
REQ-006 addr0_i / addr1_i  input  32 each  byte address of the word.
REQ-007 wdata0_i / wdata1_i  input  32 each  write data.
REQ-008 ack0_o / ack1_o  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-009 err_o  output  1  high with ack when the access was rejected.
REQ-010 rdata_o  output  32  read data, valid while any ack is high.
REQ-011 busy_o  output  1  high in any state other than IDLE.
REQ-012 gnt_o  output  1  index of the requester currently owning the memory.
REQ-013 mem_addr_o, mem_wdata_o  output  32 each  address and data to the memory.
REQ-014 mem_read_o, mem_write_o  output  1 each  memory read / write strobes.
REQ-015 mem_rdata_i  input  32  memory read data, little-endian word {b[a+3],b[a+2],b[a+1],b[a]}.

Function
REQ-016 The FSM SHALL have three states, IDLE, ACCESS and RESP; the transitions are IDLE->ACCESS when any req is high at the edge, ACCESS->RESP always, and RESP->IDLE always.
REQ-017 In IDLE with exactly one req high, that requester SHALL win.
REQ-018 In IDLE with both req high, the requester not served most recently SHALL win (round-robin); the last-served pointer SHALL update at the IDLE->ACCESS edge.
REQ-019 The winner's we, addr and wdata SHALL be latched at the IDLE->ACCESS edge; later input changes SHALL have no effect on the transaction.
REQ-020 A latched address with addr[1:0]!=0 or addr>MEM_BYTES-4 SHALL be rejected.
REQ-021 In ACCESS, for a legal access, exactly one of mem_read_o / mem_write_o SHALL be high for exactly one cycle, with mem_addr_o and mem_wdata_o driven from the latched values.
REQ-022 For a rejected access, both memory strobes SHALL stay low.
REQ-023 mem_rdata_i SHALL be captured at the ACCESS->RESP edge for reads.
REQ-024 In RESP, the winner's ack SHALL be high for exactly one cycle.
REQ-025 In RESP, rdata_o SHALL carry the captured data for a legal read and 0 for a write or a rejected access.
REQ-026 err_o SHALL equal 1 only in RESP of a rejected access.
REQ-027 Latency: with req sampled at edge k, the memory strobe SHALL be high in cycle k+1 and ack SHALL be high in cycle k+2; throughput SHALL be one access per 3 cycles.
REQ-028 Requesters hold req until ack and deassert it the cycle after ack; a req still high in IDLE SHALL be treated as a new request.
REQ-029 If req drops during ACCESS or RESP, the transaction SHALL still complete and ack SHALL still pulse.
REQ-030 ack0_o and ack1_o SHALL never be high simultaneously.
REQ-031 Memory strobes SHALL be low outside ACCESS.
REQ-032 gnt_o SHALL hold the winner index during ACCESS and RESP, and the last-served index in IDLE.

Reset
REQ-033 While rst_i is low: state IDLE; all acks, err_o and strobes 0; rdata_o 0; busy_o 0; gnt_o 1, so that port 0 wins the first tie.
REQ-034 Reset asserted mid-transaction SHALL abort it immediately (asynchronously), with no ack issued and the memory strobe dropped in the same cycle.

Verification
REQ-035 Port 0 write of 0xDEADBEEF to address 8, then port 1 read of address 8 -> mem_write_o high for exactly one cycle, ack0 two cycles after req; then ack1 with rdata_o=0xDEADBEEF and err_o=0.
REQ-036 Both req high out of reset, each held and re-asserted continuously -> grants ordered 0,1,0,1, each ack exactly 3 cycles apart.
REQ-037 Port 1 read of address 6 (misaligned) and of address 32 (MEM_BYTES=32) -> no strobes; ack1 with err_o=1 and rdata_o=0.
REQ-038 Port 0 read of address 28 (boundary) -> legal access, mem_read_o high, err_o=0.
REQ-039 req0 dropped during ACCESS -> ack0 still pulses in the following cycle.
REQ-040 rst_i pulled low during ACCESS of a write -> mem_write_o falls immediately, no ack; after release, busy_o=0 and a tie is won by port 0.
